// File: rtl/ql_clkmux_pkg.sv
// Shared definitions for the BRAM clock-select controller: select codes,
// FSM states and the request legality rule.
package ql_clkmux_pkg;

  // A-port codes
  localparam int SEL_OWN     = 0;  // own CLK_A / own CLK_B
  localparam int SEL_PL      = 1;  // preload clock
  localparam int SEL_CAS_A   = 2;  // ch0 CLK_A, non-split cascade
  localparam int SEL_A_ILLEG = 3;
  // B-port codes
  localparam int SEL_SYNC    = 1;  // own CLK_A, sync FIFO
  localparam int SEL_CAS_B   = 2;  // ch0 CLK_B (3 selects ch0 CLK_A)
  localparam int SEL_CAS_BA  = 3;

  typedef enum logic [1:0] {IDLE, GATE, SETTLE, RELEASE} state_e;

  // Channel 0 is the cascade source, so it cannot itself select a cascade clock.
  function automatic logic is_legal(input int ch, input int a, input int b);
    if (a >= SEL_A_ILLEG || b > SEL_CAS_BA) return 1'b0;
    if (ch == 0 && (a >= SEL_CAS_A || b >= SEL_CAS_B)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ql_cyc_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module ql_cyc_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ql_clkmux_ctrl.sv
// Per-channel BRAM clock-select owner: gates CKE, waits a guard time,
// commits new select codes, waits a settle time, then re-enables.
module ql_clkmux_ctrl
  import ql_clkmux_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int SEL_W      = 2,
  parameter int GUARD_CYC  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    CLK_i,
  input  logic                    RST_i,
  input  logic                    SCAN_MODE_i,
  input  logic                    REQ_VALID_i,
  output logic                    REQ_READY_o,
  input  logic [$clog2(NCH)-1:0]  REQ_CH_i,
  input  logic [SEL_W-1:0]        REQ_A_SEL_i,
  input  logic [SEL_W-1:0]        REQ_B_SEL_i,
  output logic [NCH-1:0]          CKE_A_o,
  output logic [NCH-1:0]          CKE_B_o,
  output logic [NCH*SEL_W-1:0]    A_SEL_o,
  output logic [NCH*SEL_W-1:0]    B_SEL_o,
  output logic                    BUSY_o,
  output logic                    DONE_o,
  output logic                    ERR_o
);

  localparam int CH_W = $clog2(NCH);
  localparam int MAXC = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  // SETTLE lasts SETTLE_CYC-1 cycles; RELEASE is the final low-CKE cycle.
  localparam logic [TW-1:0] GUARD_LD  = TW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'((SETTLE_CYC > 1) ? SETTLE_CYC - 2 : 0);

  state_e                       state_q;
  logic [NCH-1:0][SEL_W-1:0]    a_sel_q, b_sel_q;
  logic [NCH-1:0]               cke_a_q, cke_b_q;
  logic                         done_q, err_q;
  logic [CH_W-1:0]              pend_ch;
  logic [SEL_W-1:0]             pend_a, pend_b;

  logic                         ready, req_legal, req_null;
  logic [NCH-1:0]               gate_set;
  logic                         tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]                tmr_val;

  assign ready = (state_q == IDLE) && !SCAN_MODE_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_legal = (int'(REQ_CH_i) < NCH) &&
                is_legal(int'(REQ_CH_i), int'(REQ_A_SEL_i), int'(REQ_B_SEL_i));
    req_null  = req_legal && (a_sel_q[REQ_CH_i] == REQ_A_SEL_i) &&
                (b_sel_q[REQ_CH_i] == REQ_B_SEL_i);
    gate_set  = '0;
    for (int n = 0; n < NCH; n++) begin
      if (CH_W'(n) == REQ_CH_i ||
          (REQ_CH_i == '0 && (a_sel_q[n] >= SEL_W'(SEL_CAS_A) ||
                              b_sel_q[n] >= SEL_W'(SEL_CAS_B))))
        gate_set[n] = 1'b1;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = GUARD_LD;
    tmr_dec  = (state_q == GATE) || (state_q == SETTLE);
    if (ready && REQ_VALID_i && req_legal && !req_null) begin
      tmr_load = 1'b1;
    end else if (state_q == GATE && tmr_zero && !SCAN_MODE_i) begin
      tmr_load = 1'b1;
      tmr_val  = SETTLE_LD;
    end
  end

  ql_cyc_timer #(.W(TW)) u_timer (
    .clk      (CLK_i),
    .rst      (RST_i),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      a_sel_q <= '0;
      b_sel_q <= '0;
      cke_a_q <= '1;
      cke_b_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_ch <= '0;
      pend_a  <= '0;
      pend_b  <= '0;
    end else begin
      done_q <= 1'b0;
      if (SCAN_MODE_i) begin
        // Abort: anything already committed stays, the pending change is dropped.
        state_q <= IDLE;
        cke_a_q <= '1;
        cke_b_q <= '1;
      end else begin
        case (state_q)
          IDLE: if (REQ_VALID_i) begin
            if (!req_legal) begin
              err_q <= 1'b1;
            end else if (req_null) begin
              done_q <= 1'b1;
            end else begin
              state_q <= GATE;
              cke_a_q <= cke_a_q & ~gate_set;
              cke_b_q <= cke_b_q & ~gate_set;
              pend_ch <= REQ_CH_i;
              pend_a  <= REQ_A_SEL_i;
              pend_b  <= REQ_B_SEL_i;
            end
          end
          GATE: if (tmr_zero) begin
            a_sel_q[pend_ch] <= pend_a;
            b_sel_q[pend_ch] <= pend_b;
            state_q <= (SETTLE_CYC > 1) ? SETTLE : RELEASE;
          end
          SETTLE: if (tmr_zero) state_q <= RELEASE;
          RELEASE: begin
            cke_a_q <= '1;
            cke_b_q <= '1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign REQ_READY_o = ready;
  assign CKE_A_o     = SCAN_MODE_i ? '1 : cke_a_q;
  assign CKE_B_o     = SCAN_MODE_i ? '1 : cke_b_q;
  assign A_SEL_o     = SCAN_MODE_i ? '0 : a_sel_q;
  assign B_SEL_o     = SCAN_MODE_i ? '0 : b_sel_q;
  assign BUSY_o      = (state_q != IDLE);
  assign DONE_o      = done_q;
  assign ERR_o       = err_q;

endmodule

// File: tb/tb_ql_clkmux_ctrl.sv
// Self-checking bench for ql_clkmux_ctrl: directed scenarios plus random
// select requests checked against a per-channel code model.
module tb_ql_clkmux_ctrl;

  localparam int NCH    = 2;
  localparam int SEL_W  = 2;
  localparam int GUARD  = 4;
  localparam int SETTLE = 2;
  localparam int CH_W   = $clog2(NCH);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   scan = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [CH_W-1:0]        req_ch = '0;
  logic [SEL_W-1:0]       req_a = '0, req_b = '0;
  logic [NCH-1:0]         cke_a, cke_b;
  logic [NCH*SEL_W-1:0]   a_sel, b_sel;
  logic                   busy, done, err;

  int total = 0;
  int bad   = 0;

  // Reference model: committed codes per channel and the sticky error flag.
  int ma[NCH];
  int mb[NCH];
  bit merr;

  ql_clkmux_ctrl #(.NCH(NCH), .SEL_W(SEL_W), .GUARD_CYC(GUARD), .SETTLE_CYC(SETTLE)) dut (
    .CLK_i       (clk),
    .RST_i       (rst),
    .SCAN_MODE_i (scan),
    .REQ_VALID_i (req_valid),
    .REQ_READY_o (req_ready),
    .REQ_CH_i    (req_ch),
    .REQ_A_SEL_i (req_a),
    .REQ_B_SEL_i (req_b),
    .CKE_A_o     (cke_a),
    .CKE_B_o     (cke_b),
    .A_SEL_o     (a_sel),
    .B_SEL_o     (b_sel),
    .BUSY_o      (busy),
    .DONE_o      (done),
    .ERR_o       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*SEL_W-1:0] pack_a();
    logic [NCH*SEL_W-1:0] r = '0;
    for (int n = 0; n < NCH; n++) r[n*SEL_W +: SEL_W] = SEL_W'(ma[n]);
    return r;
  endfunction

  function automatic logic [NCH*SEL_W-1:0] pack_b();
    logic [NCH*SEL_W-1:0] r = '0;
    for (int n = 0; n < NCH; n++) r[n*SEL_W +: SEL_W] = SEL_W'(mb[n]);
    return r;
  endfunction

  task automatic check_cycle(input string tag, input logic [NCH-1:0] ecka,
                             input logic [NCH-1:0] eckb, input logic edone, input logic eready);
    check({tag, "/cke_a"}, 32'(cke_a), 32'(ecka));
    check({tag, "/cke_b"}, 32'(cke_b), 32'(eckb));
    check({tag, "/a_sel"}, 32'(a_sel), 32'(pack_a()));
    check({tag, "/b_sel"}, 32'(b_sel), 32'(pack_b()));
    check({tag, "/done"},  32'(done),  32'(edone));
    check({tag, "/ready"}, 32'(req_ready), 32'(eready));
    check({tag, "/err"},   32'(err),   32'(merr));
  endtask

  function automatic bit model_legal(int ch, int a, int b);
    if (ch >= NCH || a == 3) return 1'b0;
    if (ch == 0 && (a >= 2 || b >= 2)) return 1'b0;
    return 1'b1;
  endfunction

  // Target channel, plus every cascade user when the cascade source changes.
  function automatic logic [NCH-1:0] model_mask(int ch);
    logic [NCH-1:0] m = '0;
    for (int n = 0; n < NCH; n++)
      if (n == ch || (ch == 0 && (ma[n] >= 2 || mb[n] >= 2))) m[n] = 1'b1;
    return m;
  endfunction

  // Present a request for one cycle; returns after the accepting edge.
  task automatic start_req(input int ch, input int a, input int b);
    @(negedge clk);
    req_ch    = CH_W'(ch);
    req_a     = SEL_W'(a);
    req_b     = SEL_W'(b);
    req_valid = 1'b1;
    check("pre_ready", 32'(req_ready), 32'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input int ch, input int a, input int b);
    bit legal, nul;
    logic [NCH-1:0] mask;
    legal = model_legal(ch, a, b);
    nul   = legal && ma[ch] == a && mb[ch] == b;
    mask  = legal ? model_mask(ch) : '0;
    start_req(ch, a, b);
    if (!legal) begin
      merr = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_cycle("illegal", '1, '1, 1'b0, 1'b1);
        check("illegal/busy", 32'(busy), 32'(0));
      end
    end else if (nul) begin
      @(negedge clk);
      check_cycle("null", '1, '1, 1'b1, 1'b1);
      @(negedge clk);
      check_cycle("null_after", '1, '1, 1'b0, 1'b1);
    end else begin
      for (int k = 1; k <= GUARD + SETTLE + 1; k++) begin
        @(negedge clk);
        if (k == GUARD + 1) begin
          ma[ch] = a;
          mb[ch] = b;
        end
        if (k <= GUARD + SETTLE) begin
          check_cycle("change", ~mask, ~mask, 1'b0, 1'b0);
          check("change/busy", 32'(busy), 32'(1));
        end else begin
          check_cycle("release", '1, '1, 1'b1, 1'b1);
        end
      end
      @(negedge clk);
      check_cycle("idle", '1, '1, 1'b0, 1'b1);
      check("idle/busy", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    int a_new;
    logic [NCH-1:0] mask;
    for (int n = 0; n < NCH; n++) begin
      ma[n] = 0;
      mb[n] = 0;
    end
    merr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle("reset", '1, '1, 1'b0, 1'b1);
    check("reset/busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // ch1 onto the ch0 cascade, then reprogram the cascade source
    run_req(1, 2, 3);
    run_req(0, 1, 0);

    // Illegal request, then a legal one, then a null repeat of it
    run_req(0, 0, 2);
    run_req(1, 0, 1);
    run_req(1, 0, 1);
    run_req(1, 3, 0);

    // Random requests, legal and illegal mixed
    for (int i = 0; i < 40; i++)
      run_req(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));

    // Scan entry during GATE drops the change
    a_new = (ma[1] + 1) % 3;
    mask  = model_mask(1);
    start_req(1, a_new, mb[1]);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_cycle("scan_pre", ~mask, ~mask, 1'b0, 1'b0);
    end
    @(negedge clk);
    scan = 1'b1;
    #1;
    check("scan/cke_a", 32'(cke_a), 32'({NCH{1'b1}}));
    check("scan/cke_b", 32'(cke_b), 32'({NCH{1'b1}}));
    check("scan/a_sel", 32'(a_sel), 32'(0));
    check("scan/b_sel", 32'(b_sel), 32'(0));
    check("scan/ready", 32'(req_ready), 32'(0));
    repeat (2) begin
      @(negedge clk);
      check("scan_hold/a_sel", 32'(a_sel), 32'(0));
      check("scan_hold/done", 32'(done), 32'(0));
      check("scan_hold/busy", 32'(busy), 32'(0));
    end
    scan = 1'b0;
    #1;
    check_cycle("scan_exit", '1, '1, 1'b0, 1'b1);
    repeat (8) begin
      @(negedge clk);
      check_cycle("scan_quiet", '1, '1, 1'b0, 1'b1);
    end

    // Scan rising together with VALID: not accepted
    @(negedge clk);
    scan      = 1'b1;
    req_ch    = CH_W'(1);
    req_a     = SEL_W'((ma[1] + 1) % 3);
    req_b     = SEL_W'(mb[1]);
    req_valid = 1'b1;
    #1 check("scan_valid/ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scan      = 1'b0;
    repeat (GUARD + SETTLE + 2) begin
      @(negedge clk);
      check_cycle("scan_valid", '1, '1, 1'b0, 1'b1);
      check("scan_valid/busy", 32'(busy), 32'(0));
    end

    // Make ERR set, then reset in the middle of a change
    run_req(0, 3, 0);
    a_new = (ma[1] + 1) % 3;
    mask  = model_mask(1);
    start_req(1, a_new, mb[1]);
    for (int k = 1; k <= GUARD; k++) begin
      @(negedge clk);
      check_cycle("pre_rst", ~mask, ~mask, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      ma[n] = 0;
      mb[n] = 0;
    end
    merr = 1'b0;
    @(negedge clk);
    check_cycle("mid_rst", '1, '1, 1'b0, 1'b1);
    check("mid_rst/busy", 32'(busy), 32'(0));

    // Normal operation after reset
    run_req(1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
